// File: rtl/operand_collect_pkg.sv
// Shared types, field positions and RSR classification for the operand collect stage.
// The shift stage reads instr[25:21] and instr[11:4] directly, so SH_IMM is documented here for it.
package operand_collect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FETCH_RS = 2'd1,
        ST_VALID    = 2'd2
    } state_t;

    localparam int RN_MSB     = 19;
    localparam int RN_LSB     = 16;
    localparam int RM_MSB     = 3;
    localparam int RM_LSB     = 0;
    localparam int RS_MSB     = 11;
    localparam int RS_LSB     = 8;
    localparam int SH_IMM_MSB = 11;
    localparam int SH_IMM_LSB = 7;

    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // Register-shifted-register data processing; multiply (bit7=bit4=1) is excluded.
    function automatic logic is_rsr(input logic [31:0] instr);
        logic unused_bits;
        unused_bits = ^{instr[31:28], instr[24:8], instr[6:5], instr[3:0]};
        return (instr[27:25] == 3'b000) && !instr[7] && instr[4];
    endfunction

endpackage

// File: rtl/operand_collect_rsr_decode.sv
// Pure combinational field extraction and RSR classification of one instruction word.
module rsr_decode
    import operand_collect_pkg::*;
(
    input  logic [31:0] instr,
    output logic        rsr,
    output logic [3:0]  rn_addr,
    output logic [3:0]  rm_addr,
    output logic [3:0]  rs_addr
);

    assign rsr     = is_rsr(instr);
    assign rn_addr = instr[RN_MSB:RN_LSB];
    assign rm_addr = instr[RM_MSB:RM_LSB];
    assign rs_addr = instr[RS_MSB:RS_LSB];

endmodule

// File: rtl/operand_collect.sv
// Operand collect stage: reads Rn/Rm at accept, spends one extra cycle reading Rs for
// register-shifted-register instructions, then presents the bundle to the shift stage.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | no bundle held, ready for a new instruction
// ST_FETCH_RS | RSR instruction held, reading Rs through read port 2
// ST_VALID    | bundle presented; a new accept may overlap its consumption
module operand_collect
    import operand_collect_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    input  logic [31:0] rd1,
    input  logic [31:0] rd2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_rn,
    output logic [31:0] out_rm,
    output logic [7:0]  out_rs,
    output logic [15:0] rsr_stalls
);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] dec_instr;
    logic        dec_rsr;
    logic [3:0]  dec_rn;
    logic [3:0]  dec_rm;
    logic [3:0]  dec_rs;
    logic        accept;
    logic        fetch_done;

    // While fetching Rs the live input belongs to the next instruction, so decode the held one.
    assign dec_instr = (state == ST_FETCH_RS) ? out_instr : instr;

    rsr_decode u_rsr_decode (
        .instr   (dec_instr),
        .rsr     (dec_rsr),
        .rn_addr (dec_rn),
        .rm_addr (dec_rm),
        .rs_addr (dec_rs)
    );

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        ra1        = dec_rn;
        ra2        = dec_rm;
        accept     = 1'b0;
        fetch_done = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = dec_rsr ? ST_FETCH_RS : ST_VALID;
                end
            end
            ST_FETCH_RS: begin
                ra1        = 4'd0;
                ra2        = dec_rs;
                fetch_done = 1'b1;
                state_nxt  = ST_VALID;
            end
            ST_VALID: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        accept    = 1'b1;
                        state_nxt = dec_rsr ? ST_FETCH_RS : ST_VALID;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Flush wins over both accept and Rs completion; the held data is simply left behind.
        if (flush) begin
            state_nxt  = ST_IDLE;
            accept     = 1'b0;
            fetch_done = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_instr  <= '0;
            out_rn     <= '0;
            out_rm     <= '0;
            out_rs     <= '0;
            rsr_stalls <= '0;
        end else begin
            if (accept) begin
                out_instr <= instr;
                out_rn    <= rd1;
                out_rm    <= rd2;
                out_rs    <= '0;
            end
            if (fetch_done) begin
                out_rs <= rd2[7:0];
                if (rsr_stalls != STALL_MAX) begin
                    rsr_stalls <= rsr_stalls + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_operand_collect.sv
// Directed scenarios plus a randomized run against a transaction-level model with a register file.
module tb_operand_collect;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        flush;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_rn;
    logic [31:0] out_rm;
    logic [7:0]  out_rs;
    logic [15:0] rsr_stalls;

    logic [31:0] rf [16];
    logic        use_rf;
    logic [31:0] rd1_drv;
    logic [31:0] rd2_drv;

    int          n_cmp;
    int          n_err;
    logic [15:0] exp_stalls;

    operand_collect dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .flush      (flush),
        .ra1        (ra1),
        .ra2        (ra2),
        .rd1        (rd1),
        .rd2        (rd2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_instr  (out_instr),
        .out_rn     (out_rn),
        .out_rm     (out_rm),
        .out_rs     (out_rs),
        .rsr_stalls (rsr_stalls)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rd1 = use_rf ? rf[ra1] : rd1_drv;
        rd2 = use_rf ? rf[ra2] : rd2_drv;
    end

    function automatic bit model_rsr(input logic [31:0] w);
        return (((w >> 25) & 32'd7) == 0) && (((w >> 7) & 32'd1) == 0) && (((w >> 4) & 32'd1) == 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        instr = 32'h0; use_rf = 1'b0; rd1_drv = 32'h0; rd2_drv = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({out_instr, out_rn, out_rm, out_rs} !== 104'h0) begin n_err++; $display("FAIL reset_bundle: got %h %h %h %h want zeros", out_instr, out_rn, out_rm, out_rs); end
        n_cmp++; if (rsr_stalls !== 16'h0) begin n_err++; $display("FAIL reset_stalls: got %h want 0", rsr_stalls); end
        exp_stalls = 16'h0;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_non_rsr();
        in_valid = 1'b1; instr = 32'hE0810202; rd1_drv = 32'h11; rd2_drv = 32'h22; out_ready = 1'b0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL nonrsr_in_ready: got %b want 1", in_ready); end
        n_cmp++; if ({ra1, ra2} !== 8'h12) begin n_err++; $display("FAIL nonrsr_ra: got %h %h want 1 2", ra1, ra2); end
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL nonrsr_out_valid: got %b want 1", out_valid); end
        n_cmp++; if ({out_instr, out_rn, out_rm, out_rs} !== {32'hE0810202, 32'h11, 32'h22, 8'h00}) begin
            n_err++; $display("FAIL nonrsr_bundle: got %h %h %h %h want e0810202 11 22 00", out_instr, out_rn, out_rm, out_rs);
        end
        n_cmp++; if (rsr_stalls !== exp_stalls) begin n_err++; $display("FAIL nonrsr_stalls: got %h want %h", rsr_stalls, exp_stalls); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL nonrsr_drain: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
    endtask

    task automatic test_rsr();
        in_valid = 1'b1; instr = 32'hE0810312; rd1_drv = 32'hAA; rd2_drv = 32'hBB; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #1;
        n_cmp++; if ({in_ready, out_valid} !== 2'b00) begin n_err++; $display("FAIL rsr_fetch_hs: got ready=%b valid=%b want 0 0", in_ready, out_valid); end
        n_cmp++; if ({ra1, ra2} !== 8'h03) begin n_err++; $display("FAIL rsr_fetch_ra: got %h %h want 0 3", ra1, ra2); end
        rd2_drv = 32'h1234_5605;
        tick();
        exp_stalls = exp_stalls + 16'd1;
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rsr_out_valid: got %b want 1", out_valid); end
        n_cmp++; if ({out_rn, out_rm, out_rs} !== {32'hAA, 32'hBB, 8'h05}) begin
            n_err++; $display("FAIL rsr_bundle: got %h %h %h want aa bb 05", out_rn, out_rm, out_rs);
        end
        n_cmp++; if (rsr_stalls !== exp_stalls) begin n_err++; $display("FAIL rsr_stalls: got %h want %h", rsr_stalls, exp_stalls); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; instr = 32'hE0812003; rd1_drv = 32'h1; rd2_drv = 32'h2; out_ready = 1'b0;
        tick();
        instr = 32'hE1A01002; rd1_drv = 32'h33; rd2_drv = 32'h44;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if ({in_ready, out_valid} !== 2'b01) begin n_err++; $display("FAIL bp_hs[%0d]: got ready=%b valid=%b want 0 1", i, in_ready, out_valid); end
            n_cmp++; if ({out_instr, out_rn, out_rm} !== {32'hE0812003, 32'h1, 32'h2}) begin
                n_err++; $display("FAIL bp_hold[%0d]: got %h %h %h want e0812003 1 2", i, out_instr, out_rn, out_rm);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_instr, out_rn, out_rm} !== {1'b1, 32'hE1A01002, 32'h33, 32'h44}) begin
            n_err++; $display("FAIL bp_new: got %b %h %h %h want 1 e1a01002 33 44", out_valid, out_instr, out_rn, out_rm);
        end
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] seq [4];
        seq = '{32'hE0810202, 32'hE0823004, 32'hE0834006, 32'hE0845008};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; instr = seq[i]; rd1_drv = 32'h100 + i; rd2_drv = 32'h200 + i;
            #1;
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            n_cmp++; if ({out_valid, out_instr, out_rn} !== {1'b1, seq[i], 32'h100 + i}) begin
                n_err++; $display("FAIL b2b_out[%0d]: got %b %h %h want 1 %h %h", i, out_valid, out_instr, out_rn, seq[i], 32'h100 + i);
            end
        end
        in_valid = 1'b0;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_multiply();
        in_valid = 1'b1; instr = 32'hE0000291; rd1_drv = 32'h7; rd2_drv = 32'h9; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        n_cmp++; if ({out_valid, out_rs} !== {1'b1, 8'h00}) begin n_err++; $display("FAIL mul_latency: got valid=%b rs=%h want 1 00", out_valid, out_rs); end
        n_cmp++; if (rsr_stalls !== exp_stalls) begin n_err++; $display("FAIL mul_stalls: got %h want %h", rsr_stalls, exp_stalls); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        in_valid = 1'b1; instr = 32'hE0810312; rd1_drv = 32'h1; rd2_drv = 32'h2; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b1; rd2_drv = 32'hFF;
        tick();
        flush = 1'b0;
        #1;
        n_cmp++; if ({out_valid, in_ready} !== 2'b01) begin n_err++; $display("FAIL flush_idle: got valid=%b ready=%b want 0 1", out_valid, in_ready); end
        n_cmp++; if (rsr_stalls !== exp_stalls) begin n_err++; $display("FAIL flush_stalls: got %h want %h", rsr_stalls, exp_stalls); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_no_bundle: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        in_valid = 1'b1; instr = 32'hE0810202; rd1_drv = 32'h55; rd2_drv = 32'h66; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if ({out_valid, out_instr, out_rn, out_rm, out_rs, rsr_stalls} !== 121'h0) begin
            n_err++; $display("FAIL areset_valid: got %b %h %h %h %h %h want zeros", out_valid, out_instr, out_rn, out_rm, out_rs, rsr_stalls);
        end
        exp_stalls = 16'h0;
        tick();
        reset = 1'b0;
        tick();
        in_valid = 1'b1; instr = 32'hE0810312; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({out_valid, rsr_stalls} !== 17'h0) begin n_err++; $display("FAIL areset_fetch[%0d]: got valid=%b stalls=%h want 0 0", i, out_valid, rsr_stalls); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        bit          m_full;
        bit          m_fetch;
        logic [31:0] e_instr;
        logic [31:0] e_rn;
        logic [31:0] e_rm;
        logic [7:0]  e_rs;
        logic [31:0] rs_word;
        bit          e_in_ready;
        bit          e_out_valid;
        logic [3:0]  e_ra1;
        logic [3:0]  e_ra2;
        int          kind;
        m_full = 0; m_fetch = 0;
        e_instr = '0; e_rn = '0; e_rm = '0; e_rs = '0;
        for (int r = 0; r < 16; r++) rf[r] = $urandom;
        use_rf = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            kind      = $urandom % 3;
            instr     = $urandom;
            if (kind == 0) begin
                instr[27:25] = 3'b000; instr[7] = 1'b0; instr[4] = 1'b1;
            end else if (kind == 1) begin
                instr[27:25] = 3'b000; instr[7] = 1'b1; instr[4] = 1'b1;
            end
            #2;
            e_in_ready  = !m_fetch && (!m_full || out_ready);
            e_out_valid = m_full && !m_fetch;
            e_ra1 = m_fetch ? 4'd0 : instr[19:16];
            e_ra2 = m_fetch ? e_instr[11:8] : instr[3:0];
            n_cmp++; if ({in_ready, out_valid} !== {e_in_ready, e_out_valid}) begin
                n_err++; $display("FAIL rnd_hs[%0d]: got ready=%b valid=%b want %b %b", c, in_ready, out_valid, e_in_ready, e_out_valid);
            end
            n_cmp++; if ({ra1, ra2} !== {e_ra1, e_ra2}) begin n_err++; $display("FAIL rnd_ra[%0d]: got %h %h want %h %h", c, ra1, ra2, e_ra1, e_ra2); end
            n_cmp++; if (rsr_stalls !== exp_stalls) begin n_err++; $display("FAIL rnd_stalls[%0d]: got %h want %h", c, rsr_stalls, exp_stalls); end
            if (e_out_valid) begin
                n_cmp++; if ({out_instr, out_rn, out_rm, out_rs} !== {e_instr, e_rn, e_rm, e_rs}) begin
                    n_err++; $display("FAIL rnd_bundle[%0d]: got %h %h %h %h want %h %h %h %h", c, out_instr, out_rn, out_rm, out_rs, e_instr, e_rn, e_rm, e_rs);
                end
            end
            if (flush) begin
                m_full = 0; m_fetch = 0;
            end else if (m_fetch) begin
                m_fetch = 0;
                if (exp_stalls != 16'hFFFF) exp_stalls = exp_stalls + 16'd1;
            end else begin
                if (e_out_valid && out_ready) m_full = 0;
                if (e_in_ready && in_valid) begin
                    m_full  = 1;
                    m_fetch = model_rsr(instr);
                    e_instr = instr;
                    e_rn    = rf[instr[19:16]];
                    e_rm    = rf[instr[3:0]];
                    rs_word = rf[instr[11:8]];
                    e_rs    = m_fetch ? rs_word[7:0] : 8'h00;
                end
            end
            tick();
        end
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0; use_rf = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        exp_stalls = 16'h0;
        test_reset();
        test_non_rsr();
        test_rsr();
        test_backpressure();
        test_back_to_back();
        test_multiply();
        test_flush();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
